// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the CPU run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_MAX_CYCLES = 1000;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/run_ctrl_edge.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of 'in'.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset, releases it, clock-enables it in
// free-run or single-step mode, and stops it on halt or cycle budget.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             halted,
  output logic             timeout
);

  localparam int               RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  // The counter must be able to hold MAX_CYCLES itself after a timeout.
  if (CNT_W < 63 && (64'd1 << CNT_W) <= 64'(MAX_CYCLES)) begin : g_cnt_w_chk
    $error("run_ctrl: CNT_W too narrow for MAX_CYCLES");
  end
  if (RST_CYCLES < 1 || MAX_CYCLES < 1) begin : g_param_chk
    $error("run_ctrl: RST_CYCLES and MAX_CYCLES must be >= 1");
  end

  state_t           state, nxt;
  logic [RW-1:0]    rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             halted_nxt, timeout_nxt;
  logic             step_pulse;

  edge_pulse u_step_edge (
    .clk   (clk),
    .reset (reset),
    .in    (step),
    .pulse (step_pulse)
  );

  // State, reset-phase counter, cycle counter and completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= nxt;
      rst_cnt   <= rst_cnt_nxt;
      cycle_cnt <= cnt_nxt;
      halted    <= halted_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state and output decode. In RUN, cpu_en is masked by abort so an
  // aborted cycle is neither executed nor counted and cycle_cnt holds.
  always_comb begin
    nxt         = state;
    rst_cnt_nxt = rst_cnt;
    cnt_nxt     = cycle_cnt;
    halted_nxt  = halted;
    timeout_nxt = timeout;
    cpu_reset   = 1'b0;
    cpu_en      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        cpu_reset = 1'b1;
        if (start && !abort) begin
          nxt         = RST;
          rst_cnt_nxt = '0;
          cnt_nxt     = '0;
          halted_nxt  = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      RST: begin
        cpu_reset = 1'b1;
        if (abort) begin
          nxt = IDLE;
        end else if (rst_cnt == RST_LAST) begin
          nxt         = RUN;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + RW'(1);
        end
      end
      RUN: begin
        cpu_en = (~step_mode | step_pulse) & ~abort;
        if (abort) begin
          nxt = IDLE;
        end else if (cpu_en) begin
          cnt_nxt = cycle_cnt + CNT_W'(1);
          if (halt_req) begin
            nxt        = DONE;
            halted_nxt = 1'b1;
          end else if (cycle_cnt == CNT_LAST) begin
            nxt         = DONE;
            timeout_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (abort) begin
          nxt         = IDLE;
          halted_nxt  = 1'b0;
          timeout_nxt = 1'b0;
        end else if (start) begin
          nxt         = RST;
          rst_cnt_nxt = '0;
          cnt_nxt     = '0;
          halted_nxt  = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: cycle-by-cycle vector table plus hand-written
// multi-cycle runs (budget timeout, halt, abort, back-to-back runs, MAX_CYCLES=8).
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (defaults: RST_CYCLES=2, MAX_CYCLES=1000)
  logic        reset, start, abort, step_mode, step, halt_req;
  logic        cpu_reset, cpu_en, done, halted, timeout;
  logic [15:0] cycle_cnt;

  run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .halt_req(halt_req),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .cycle_cnt(cycle_cnt),
    .done(done), .halted(halted), .timeout(timeout)
  );

  // Small-budget DUT (MAX_CYCLES=8)
  logic       b_start, b_halt;
  logic       b_cr, b_en, b_done, b_halted, b_to;
  logic [3:0] b_cnt;

  run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(b_start), .abort(1'b0),
    .step_mode(1'b0), .step(1'b0), .halt_req(b_halt),
    .cpu_reset(b_cr), .cpu_en(b_en), .cycle_cnt(b_cnt),
    .done(b_done), .halted(b_halted), .timeout(b_to)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // i = {reset,start,abort,step_mode,step,halt_req}; o = {cpu_reset,cpu_en};
  // f = {done,halted,timeout}; expectations are the values seen during the
  // cycle, before the edge that consumes the inputs.
  typedef struct {
    logic [5:0] i;
    logic [1:0] o;
    int         cnt;
    logic [2:0] f;
    int         rep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [5:0] i, logic [1:0] o, int cnt, logic [2:0] f, int rep);
    vec_t v;
    v.i = i; v.o = o; v.cnt = cnt; v.f = f; v.rep = rep;
    tbl.push_back(v);
  endfunction

  // Issue a one-cycle start and measure the cpu_reset phase that follows.
  task automatic start_run(input string nm);
    int rc;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!cpu_reset) break;
      rc++;
      if (rc == 1) begin
        chk({nm, "_cnt_clr"}, cycle_cnt, 0);
        chk({nm, "_flags_clr"}, {done, halted, timeout}, 0);
      end
      @(negedge clk);
    end
    chk({nm, "_rst_cycles"}, rc, 2);
  endtask

  // Free-run until done; raise halt_req on enabled cycle number halt_at.
  task automatic run_until_done(input int halt_at, output int en_cycles);
    en_cycles = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done) break;
      halt_req = (halt_at != 0 && cpu_en && en_cycles + 1 == halt_at);
      if (cpu_en) en_cycles++;
      @(negedge clk);
      #1;
    end
    halt_req = 1'b0;
    chk("run_reached_done", done, 1);
  endtask

  // Run the MAX_CYCLES=8 instance, optionally halting on its last budget cycle.
  task automatic run8(input logic do_halt, input string nm);
    int en_c;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    en_c = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (b_done) break;
      b_halt = do_halt && b_en && (b_cnt == 4'd7);
      if (b_en) en_c++;
      @(negedge clk);
    end
    b_halt = 1'b0;
    chk({nm, "_done"}, b_done, 1);
    chk({nm, "_en_cycles"}, en_c, 8);
    chk({nm, "_cnt"}, b_cnt, 8);
    chk({nm, "_halted"}, b_halted, do_halt);
    chk({nm, "_timeout"}, b_to, !do_halt);
  endtask

  initial begin
    int en_c;
    int idx;
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    step = 1'b0; halt_req = 1'b0; b_start = 1'b0; b_halt = 1'b0;

    //   {rst,st,ab,sm,stp,hlt}  {cr,en}  cnt  {dn,h,t}  rep
    add(6'b000100, 2'b10, 0, 3'b000, 2);  // IDLE after reset
    add(6'b010100, 2'b10, 0, 3'b000, 1);  // start -> RST
    add(6'b000100, 2'b10, 0, 3'b000, 2);  // RST phase
    add(6'b000100, 2'b00, 0, 3'b000, 2);  // RUN, single-step, no step
    add(6'b000110, 2'b01, 0, 3'b000, 1);  // step rises
    add(6'b000111, 2'b00, 1, 3'b000, 9);  // step held; halt_req ignored while disabled
    add(6'b000100, 2'b00, 1, 3'b000, 1);
    add(6'b000110, 2'b01, 1, 3'b000, 1);  // pulse 2
    add(6'b000100, 2'b00, 2, 3'b000, 1);
    add(6'b000110, 2'b01, 2, 3'b000, 1);  // pulse 3
    add(6'b000100, 2'b00, 3, 3'b000, 1);
    add(6'b000110, 2'b01, 3, 3'b000, 1);  // pulse 4
    add(6'b000110, 2'b00, 4, 3'b000, 2);  // held, no extra cycles
    add(6'b000010, 2'b01, 4, 3'b000, 1);  // switch to free-run same cycle
    add(6'b000000, 2'b01, 5, 3'b000, 1);
    add(6'b000100, 2'b00, 6, 3'b000, 1);  // back to step mode, no pulse
    add(6'b000001, 2'b01, 6, 3'b000, 1);  // free-run + halt: counted
    add(6'b000000, 2'b00, 7, 3'b110, 2);  // DONE, halted
    add(6'b000001, 2'b00, 7, 3'b110, 1);  // halt in DONE ignored
    add(6'b011000, 2'b00, 7, 3'b110, 1);  // abort beats start
    add(6'b000000, 2'b10, 7, 3'b000, 1);  // IDLE, count held, flags clear
    add(6'b010000, 2'b10, 7, 3'b000, 1);  // start
    add(6'b000000, 2'b10, 0, 3'b000, 2);  // RST, count cleared
    add(6'b000000, 2'b01, 0, 3'b000, 1);
    add(6'b000000, 2'b01, 1, 3'b000, 1);
    add(6'b110000, 2'b01, 2, 3'b000, 1);  // reset (with start) mid-RUN
    add(6'b000000, 2'b10, 0, 3'b000, 1);  // IDLE after reset
    add(6'b010000, 2'b10, 0, 3'b000, 1);  // start
    add(6'b001000, 2'b10, 0, 3'b000, 1);  // abort in RST
    add(6'b000000, 2'b10, 0, 3'b000, 1);  // back in IDLE

    repeat (2) @(posedge clk);
    idx = 0;
    foreach (tbl[n]) begin
      for (int r = 0; r < tbl[n].rep; r++) begin
        @(negedge clk);
        {reset, start, abort, step_mode, step, halt_req} = tbl[n].i;
        #1;
        chk($sformatf("vec%0d_ctl", idx), {cpu_reset, cpu_en}, tbl[n].o);
        chk($sformatf("vec%0d_cnt", idx), cycle_cnt, tbl[n].cnt);
        chk($sformatf("vec%0d_flags", idx), {done, halted, timeout}, tbl[n].f);
        idx++;
      end
    end
    {reset, start, abort, step_mode, step, halt_req} = 6'b0;

    // Full free run to the 1000-cycle budget
    start_run("run1");
    run_until_done(0, en_c);
    chk("run1_en_cycles", en_c, 1000);
    chk("run1_cnt", cycle_cnt, 1000);
    chk("run1_flags", {done, halted, timeout}, 3'b101);
    chk("run1_done_outs", {cpu_reset, cpu_en}, 2'b00);

    // Restart from DONE behaves like the first run
    start_run("run2");
    run_until_done(0, en_c);
    chk("run2_en_cycles", en_c, 1000);
    chk("run2_cnt", cycle_cnt, 1000);
    chk("run2_flags", {done, halted, timeout}, 3'b101);

    // Halt on RUN cycle 37
    start_run("halt37");
    run_until_done(37, en_c);
    chk("halt37_en_cycles", en_c, 37);
    chk("halt37_cnt", cycle_cnt, 37);
    chk("halt37_flags", {done, halted, timeout}, 3'b110);

    // Abort together with start at cycle_cnt == 20
    start_run("abort");
    for (int k = 0; k < 100; k++) begin
      if (cycle_cnt == 16'd20) break;
      @(negedge clk);
      #1;
    end
    chk("abort_reach20", cycle_cnt, 20);
    abort = 1'b1; start = 1'b1;
    #1;
    chk("abort_cycle_en", cpu_en, 0);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #1;
    chk("abort_ctl", {cpu_reset, cpu_en}, 2'b10);
    chk("abort_cnt", cycle_cnt, 20);
    chk("abort_flags", {done, halted, timeout}, 3'b000);

    // MAX_CYCLES = 8: halt on the last budget cycle wins, then plain timeout
    run8(1'b1, "m8_halt");
    run8(1'b0, "m8_to");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles cpu_reset is held after start.
REQ-002 Parameter MAX_CYCLES, default 1000: cycle budget before forced stop.
REQ-003 Parameter CNT_W, default 16: width of cycle_cnt; SHALL satisfy 2^CNT_W > MAX_CYCLES (elaboration-time check).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begins a run from IDLE or DONE.
REQ-007 abort  in  1  level; returns to IDLE from any state.
REQ-008 step_mode  in  1  1 = single-step, 0 = free-run.
REQ-009 step  in  1  step request; one CPU cycle per rising edge.
REQ-010 halt_req  in  1  CPU reports halt, sampled only when cpu_en=1.
REQ-011 cpu_reset  out  1  synchronous reset to CPU core.
REQ-012 cpu_en  out  1  CPU clock-enable, combinational from state and step pulse.
REQ-013 cycle_cnt  out  CNT_W  enabled CPU cycles executed this run.
REQ-014 done / halted / timeout  out  1 each  run finished / by halt / by budget.

Function
REQ-015 FSM states SHALL be IDLE, RST, RUN, DONE.
REQ-016 IDLE: cpu_reset=1, cpu_en=0; start=1 -> RST, clearing cycle_cnt, done, halted, timeout.
REQ-017 RST: cpu_reset=1, cpu_en=0; internal counter runs RST_CYCLES cycles, then -> RUN; cpu_reset low from first RUN cycle.
REQ-018 RUN, step_mode=0: cpu_en=1 every cycle.
REQ-019 RUN, step_mode=1: cpu_en=1 for exactly one cycle per step rising edge (step_pulse = step & ~step_q, step_q registered); held step yields one cycle only.
REQ-020 cycle_cnt SHALL increment by 1 on each edge where cpu_en=1; never otherwise.
REQ-021 halt_req=1 with cpu_en=1: that cycle counts; -> DONE next edge, halted=1.
REQ-022 cpu_en=1 and cycle_cnt==MAX_CYCLES-1 without halt_req: -> DONE, timeout=1, cycle_cnt=MAX_CYCLES.
REQ-023 Simultaneous halt_req and budget exhaustion: halted=1, timeout=0.
REQ-024 DONE: cpu_en=0, cpu_reset=0, done=1; cycle_cnt and flags held; start=1 -> RST with clearing per REQ-016.
REQ-025 abort=1 in RST, RUN or DONE -> IDLE next edge; abort has priority over start, halt_req and timeout; cycle_cnt held, flags cleared.
REQ-026 step_mode change mid-RUN takes effect in the same cycle; no lost or duplicated count.
REQ-027 halt_req while cpu_en=0 SHALL be ignored.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, cycle_cnt=0, done=0, halted=0, timeout=0, step_q=0, RST counter=0; cpu_reset=1, cpu_en=0 from that edge.
REQ-029 reset SHALL override abort, start and all other inputs, including mid-RUN.

Structure
REQ-030 Shared package run_ctrl_pkg SHALL hold the state enumeration and default values of RST_CYCLES, MAX_CYCLES, CNT_W.
REQ-031 Step edge detection SHALL be a separate sub-module edge_pulse (clk, reset, in, pulse).

Verification
REQ-032 reset, start=1 one cycle, step_mode=0, halt_req never -> cpu_reset high 2 cycles after start, then 1000 cpu_en cycles, done=1, timeout=1, cycle_cnt=1000.
REQ-033 Free-run, halt_req=1 in cycle 37 of RUN -> DONE next edge, cycle_cnt=37, halted=1, timeout=0.
REQ-034 step_mode=1, step held high 10 cycles then 3 separate pulses -> cycle_cnt=4, cpu_en high exactly 4 cycles.
REQ-035 MAX_CYCLES=8, halt_req=1 on 8th enabled cycle -> halted=1, timeout=0, cycle_cnt=8.
REQ-036 abort=1 and start=1 together in RUN at cycle_cnt=20 -> IDLE, cycle_cnt=20, flags 0; reset mid-RUN -> all outputs per REQ-028 next cycle.
REQ-037 After DONE, start=1 -> cycle_cnt=0, flags cleared, cpu_reset high 2 cycles, second run behaves as first.
